// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the chunked magnitude comparator.
// The requester drives operands and start; the comparator returns status and the result.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
);
  localparam int CW = $clog2(WIDTH / CHUNK + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             eq;
  logic             a_less_b;
  logic             a_gt_b;
  logic [CW-1:0]    chunks_used;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, eq, a_less_b, a_gt_b, chunks_used
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, eq, a_less_b, a_gt_b, chunks_used
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands CHUNK bits per
// cycle from the MSB end, with optional early exit on the first differing chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input logic                   clk,
  input logic                   rst,
  seq_magnitude_comparator_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    idx;
  logic             diff_seen, diff_gt;
  logic             busy, load, decide, last;
  logic [CHUNK-1:0] a_top, b_top;
  logic             c_gt, c_lt;
  logic             done_r, eq_r, lt_r, gt_r;
  logic [CW-1:0]    cu_r;

  // Operands shift left each RUN cycle, so the chunk under test is always on top.
  assign a_top = a_sh[WIDTH-1 -: CHUNK];
  assign b_top = b_sh[WIDTH-1 -: CHUNK];
  assign c_gt  = a_top > b_top;
  assign c_lt  = a_top < b_top;
  assign last  = (idx == CW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (decide)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    load   = (state == IDLE) && bus.start;
    decide = busy && (last || ((EARLY_EXIT != 0) && (c_gt || c_lt)));
  end

  // Flipping the sign bit once at capture turns the signed compare of the top
  // chunk into an unsigned one; lower chunks are unaffected.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sh <= bus.A ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
      b_sh <= bus.B ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
    end else if (busy) begin
      a_sh <= a_sh << CHUNK;
      b_sh <= b_sh << CHUNK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      diff_seen <= 1'b0;
      diff_gt   <= 1'b0;
      done_r    <= 1'b0;
      eq_r      <= 1'b0;
      lt_r      <= 1'b0;
      gt_r      <= 1'b0;
      cu_r      <= '0;
    end else begin
      done_r <= decide;
      if (load) begin
        idx       <= '0;
        diff_seen <= 1'b0;
      end else if (busy) begin
        idx <= idx + CW'(1);
        if (!diff_seen && (c_gt || c_lt)) begin
          diff_seen <= 1'b1;
          diff_gt   <= c_gt;
        end
      end
      // The first unequal chunk decides; later chunks only matter without early exit.
      if (decide) begin
        if (diff_seen) begin
          eq_r <= 1'b0;
          gt_r <= diff_gt;
          lt_r <= !diff_gt;
        end else begin
          eq_r <= !(c_gt || c_lt);
          gt_r <= c_gt;
          lt_r <= c_lt;
        end
        cu_r <= (EARLY_EXIT != 0) ? idx + CW'(1) : CW'(NCHUNK);
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_r;
  assign bus.eq          = eq_r;
  assign bus.a_less_b    = lt_r;
  assign bus.a_gt_b      = gt_r;
  assign bus.chunks_used = cu_r;
endmodule
